// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : receiver state encoding and framing constants for uart_rx_fifo
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock show-ahead FIFO; full/empty decided by occupancy
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign do_rd = rd_en & ~empty;
  // A write on full is accepted only when a pop frees the head slot this cycle.
  assign do_wr = wr_en & (~full | rd_en);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : 16x-oversampled UART receiver feeding a show-ahead FIFO.
// Optional even-parity framing and parity_err flag: define UART_RX_PARITY_EN.
// Rev 1.0
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          framing_err
);

  localparam int               DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
`ifdef UART_RX_PARITY_EN
  localparam int               FRAME_BITS = DATA_BITS + 1;
`else
  localparam int               FRAME_BITS = DATA_BITS;
`endif
  localparam logic [3:0]       MID_PH   = 4'(MID_SAMPLE);
  localparam logic [3:0]       LAST_PH  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic                  rxd_meta, rxd_s, rxd_d;
  logic                  fall;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  rx_state_t             state, state_n;
  logic [3:0]            phase, phase_n;
  logic [3:0]            bit_cnt, bit_n;
  logic [FRAME_BITS-1:0] shift, shift_n;
  logic                  brk_wait, brk_n;
  logic                  push, push_n;
  logic                  ferr_set;
  logic                  fifo_empty, fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_d    <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      brk_wait <= 1'b0;
      push     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      brk_wait <= brk_n;
      push     <= push_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    bit_n    = bit_cnt;
    shift_n  = shift;
    brk_n    = brk_wait;
    push_n   = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          phase_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (phase == MID_PH) begin
            phase_n = '0;
            bit_n   = '0;
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (phase == LAST_PH) begin
            phase_n = '0;
            shift_n = {rxd_s, shift[FRAME_BITS-1:1]};
            bit_n   = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state_n = STOP;
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      STOP: begin
        // After a low stop bit, hold here until the line idles so a break is not seen as a new start.
        if (brk_wait) begin
          if (rxd_s) begin
            brk_n   = 1'b0;
            state_n = IDLE;
          end
        end else if (tick) begin
          if (phase == LAST_PH) begin
            phase_n = '0;
            if (rxd_s) begin
              push_n  = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_set = 1'b1;
              brk_n    = 1'b1;
            end
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (push && fifo_full && !rd_en) overrun <= 1'b1;
      else if (clr_err)                overrun <= 1'b0;
      if (ferr_set)     framing_err <= 1'b1;
      else if (clr_err) framing_err <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the xor over data plus parity bit must be zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              parity_err <= 1'b0;
    else if (push && (^shift)) parity_err <= 1'b1;
    else if (clr_err)          parity_err <= 1'b0;
  end
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (shift[DATA_BITS-1:0]),
    .rd_en   (rd_en),
    .rd_data (rx_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign rx_valid = ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : directed + randomized frames against a frame-level queue model
// Rev 1.0
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 460_800;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_HZ / (BAUD * 16);
  localparam int BIT_CLKS = 16 * DIV;
  localparam int LAT_LO   = 9 * BIT_CLKS + BIT_CLKS / 2 - BIT_CLKS / 4;
  localparam int LAT_HI   = 9 * BIT_CLKS + BIT_CLKS / 2 + BIT_CLKS / 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       overrun;
  logic       framing_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       flip_parity = 1'b0;
  logic       m_perr = 1'b0;
`endif

  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .fifo_count  (fifo_count),
    .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .framing_err (framing_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".valid"}, 32'(rx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".data"}, 32'(rx_data), 32'(q[0]));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".framing"}, 32'(framing_err), 32'(m_ferr));
`ifdef UART_RX_PARITY_EN
    chk({tag, ".parity"}, 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^b) ^ flip_parity);
`endif
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else begin
`ifdef UART_RX_PARITY_EN
      if (flip_parity) m_perr = 1'b1;
`endif
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_ok);
    send_bits(b);
    bit_time(stop_ok);
    if (!stop_ok) begin
      bit_time(1'b0);
      bit_time(1'b1);
    end
    model_frame(b, stop_ok);
  endtask

  task automatic read_one(input string tag);
    chk({tag, ".valid"}, 32'(rx_valid), 32'd1);
    chk({tag, ".data"}, 32'(rx_data), 32'(q[0]));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    m_perr = 1'b0;
`endif
  endtask

  initial begin
    int         lat;
    logic       found;
    logic [7:0] b;

    repeat (5) @(negedge clk);
    chk_all("in_reset");
    chk("in_reset.rx_data", 32'(rx_data), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("post_reset");

    // 0xA5: first push must land roughly mid stop bit, not earlier.
    send_bits(8'hA5);
    rxd   = 1'b1;
    lat   = 9 * BIT_CLKS;
    found = 1'b0;
    for (int k = 0; k < BIT_CLKS && !found; k++) begin
      @(negedge clk);
      lat++;
      if (rx_valid) found = 1'b1;
    end
    chk("a5.latency_window", 32'(found && lat >= LAT_LO && lat <= LAT_HI), 32'd1);
    repeat (BIT_CLKS) @(negedge clk);
    model_frame(8'hA5, 1'b1);
    chk_all("a5");
    read_one("a5.read");
    chk_all("a5.after_read");

    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    chk_all("empty_read");

    rxd = 1'b0;
    repeat (BIT_CLKS / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk_all("glitch");

    frame(8'h3C, 1'b0);
    chk_all("framing");
    clear_flags();
    chk_all("framing.cleared");

    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      frame(b, 1'($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 150)) @(negedge clk);
      if (q.size() != 0 && $urandom_range(0, 1) == 1) read_one("rand.read");
      chk_all("rand");
    end
    while (q.size() != 0) read_one("rand.drain");
    clear_flags();
    chk_all("rand.done");

    for (int i = 0; i <= DEPTH; i++) frame(8'(i), 1'b1);
    chk_all("overrun");
    while (q.size() != 0) read_one("overrun.drain");
    chk_all("overrun.empty");
    clear_flags();
    chk_all("overrun.cleared");

    for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 1'b1);
    chk_all("full");
    b = 8'($urandom);
    send_bits(b);
    rxd   = 1'b1;
    found = 1'b0;
    // The push strobe is internal; it only times the coincident read.
    for (int k = 0; k < BIT_CLKS && !found; k++) begin
      @(negedge clk);
      if (dut.push) begin
        chk("coinc.head", 32'(rx_data), 32'(q[0]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        found = 1'b1;
      end
    end
    chk("coinc.push_seen", 32'(found), 32'd1);
    repeat (BIT_CLKS) @(negedge clk);
    void'(q.pop_front());
    q.push_back(b);
    chk_all("coinc");
    while (q.size() != 0) read_one("coinc.drain");
    chk_all("coinc.empty");

    frame(8'h77, 1'b1);
    frame(8'h3C, 1'b0);
    chk_all("pre_reset");
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rxd = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset_n = 1'b0;
    rxd     = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    chk_all("mid_reset");
    chk("mid_reset.rx_data", 32'(rx_data), 32'd0);
    reset_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk_all("after_reset");
    frame(8'h55, 1'b1);
    chk_all("after_reset.55");
    read_one("after_reset.read");

`ifdef UART_RX_PARITY_EN
    flip_parity = 1'b1;
    frame(8'h01, 1'b1);
    flip_parity = 1'b0;
    chk_all("parity");
    read_one("parity.read");
    clear_flags();
    chk_all("parity.cleared");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the receive FIFO entries (power of two, minimum 4).
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rxd, input, 1, asynchronous serial line with idle high (GPIO_1 RXD pin).
REQ-007 SHALL have port rd_en, input, 1, which pops the FIFO head.
REQ-008 SHALL have port clr_err, input, 1, which clears the sticky error flags.
REQ-009 SHALL have port rx_data, output, 8, the FIFO head byte (show-ahead).
REQ-010 SHALL have port rx_valid, output, 1, asserted when the FIFO is non-empty.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, the current occupancy.
REQ-012 SHALL have port overrun, output, 1, a sticky flag set when a byte is dropped on full.
REQ-013 SHALL have port framing_err, output, 1, a sticky flag set when the stop bit is sampled low.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use.
REQ-015 SHALL generate a 16x oversample tick every DIV=CLK_HZ/(BAUD*16) clocks (integer division) from a free-running divider, so DIV=27 at the defaults.
REQ-016 SHALL implement states IDLE, START, DATA, STOP.
REQ-017 In IDLE, SHALL move to START on a synchronized falling edge and restart the tick phase counter at 0.
REQ-018 In START, SHALL sample at tick 7; if the sample is low, go to DATA, and if high (glitch), return to IDLE without a push or error.
REQ-019 In DATA, SHALL sample every 16 ticks, LSB first, for 8 bits, then go to STOP.
REQ-020 In STOP, SHALL sample the stop bit 16 ticks after the last data bit:
- stop bit high: push the byte, return to IDLE.
- stop bit low: discard the byte, set framing_err, go to IDLE only after rxd is sampled high (break handling).
REQ-021 Push latency SHALL be 1 clock after the stop-bit sample; rx_valid rises on the next clock.
REQ-022 A push when fifo_count==FIFO_DEPTH and rd_en is low SHALL drop the byte and set overrun; FIFO contents are unchanged.
REQ-023 A push and pop in the same cycle SHALL both take effect, including when full, with no overrun and fifo_count unchanged.
REQ-024 rd_en while empty SHALL be ignored; the pointers and count do not change.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by fifo_count.
REQ-026 clr_err SHALL clear both sticky flags next clock; a simultaneous set event SHALL win over clr_err.

Reset
REQ-027 reset_n low SHALL force IDLE, divider=0, pointers and count 0, rx_valid=0, rx_data=0, overrun=0, framing_err=0, and synchronizer=1.
REQ-028 Reset mid-frame SHALL abandon the frame; after release the receiver waits for a fresh falling edge.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined:
- the frame has an even-parity bit between D7 and the stop bit.
- a sticky output parity_err (1 bit, cleared by clr_err) is added.
- a byte with bad parity is still pushed and sets parity_err.
REQ-030 Without UART_RX_PARITY_EN, SHALL use 8N1 framing and SHALL NOT have a parity_err port.

Structure
REQ-031 Package uart_pkg SHALL hold the rx state enum, OVERSAMPLE=16, MID_SAMPLE=7, and the DATA_BITS=8 constant.
REQ-032 The FIFO SHALL be a sub-module sync_fifo (parameterized width and depth, show-ahead) instantiated once.

Verification (defaults: bit = 432 clocks)
REQ-033 Send 0xA5 in 8N1 -> rx_valid=1 with rx_data=0xA5 about 9.5 bit times after the start edge; rd_en pulse -> rx_valid=0, fifo_count=0.
REQ-034 Apply a 100-clock low glitch on idle rxd -> no push, state returns to IDLE, no flags set.
REQ-035 Send 0x3C with the stop bit held low -> no push, framing_err=1; clr_err -> 0.
REQ-036 Send 17 bytes 0x00..0x10 with no reads -> fifo_count=16, overrun=1, and reads return 0x00..0x0F in order.
REQ-037 With the FIFO full, a stop-bit push coincident with rd_en -> fifo_count stays 16, overrun=0, and the last read returns the new byte.
REQ-038 Assert reset_n low at DATA bit 4, then release -> all outputs at reset values, and the next clean 0x55 is received correctly; with UART_RX_PARITY_EN, 0x01 sent with parity 0 -> parity_err=1 and the byte is still pushed.
